// File: rtl/pixel_compositor_pkg.sv
// Shared types and constants for the sprite pixel compositor: RGB444 pixel,
// default colours, flash FSM encoding and the nibble-saturating brighten helper.
package pixel_compositor_pkg;

    typedef logic [11:0] rgb444_t;

    localparam rgb444_t DEFAULT_BG_COLOR  = 12'h000;
    localparam rgb444_t DEFAULT_KEY_COLOR = 12'hF0F;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLASH = 1'b1
    } flash_state_t;

    // Adds 4 to every nibble independently, clamping at 4'hF with no carry.
    function automatic rgb444_t brighten(input rgb444_t pix);
        rgb444_t    result;
        logic [4:0] sum;
        result = '0;
        for (int n = 0; n < 3; n++) begin
            sum = {1'b0, pix[4*n +: 4]} + 5'd4;
            result[4*n +: 4] = sum[4] ? 4'hF : sum[3:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register used to align sync/blank flags with ROM data.
// DEPTH of 0 degenerates to a plain wire.
module sync_delay #(
    parameter int                DEPTH       = 1,
    parameter int                WIDTH       = 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stages [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stages[i] <= RESET_VALUE;
                    end
                end else begin
                    stages[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign q = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/pixel_compositor.sv
// Priority sprite compositor with a click-triggered layer flash lasting a number of frames.
// Define COLOR_KEY_TRANSPARENCY_EN to make KEY_COLOR pixels transparent.
module pixel_compositor
    import pixel_compositor_pkg::*;
#(
    parameter int      NUM_LAYERS   = 4,
    parameter int      ROM_LATENCY  = 1,
    parameter rgb444_t BG_COLOR     = DEFAULT_BG_COLOR,
    parameter rgb444_t KEY_COLOR    = DEFAULT_KEY_COLOR,
    parameter int      FLASH_LAYER  = 0,
    parameter int      FLASH_FRAMES = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     hsync_in,
    input  logic                     vsync_in,
    input  logic                     video_on_in,
    input  logic [NUM_LAYERS*12-1:0] layer_pixel,
    input  logic [NUM_LAYERS-1:0]    layer_valid,
    input  logic                     click,
    output logic                     hsync,
    output logic                     vsync,
    output logic [11:0]              rgb,
    output logic                     flash_active
);

    logic d_hsync;
    logic d_vsync;
    logic d_video_on;

    sync_delay #(
        .DEPTH       (ROM_LATENCY),
        .WIDTH       (3),
        .RESET_VALUE (3'b110)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .d     ({hsync_in, vsync_in, video_on_in}),
        .q     ({d_hsync, d_vsync, d_video_on})
    );

    flash_state_t state;
    flash_state_t state_next;
    logic [7:0]   frame_count;
    logic [7:0]   frame_count_next;
    logic         vsync_prev;
    logic         vsync_fall;

    // Frame counting uses the undelayed vsync so it tracks the scan generator directly.
    assign vsync_fall = vsync_prev & ~vsync_in;

    always_comb begin
        state_next       = state;
        frame_count_next = frame_count;
        unique case (state)
            ST_IDLE: begin
                if (click) begin
                    state_next       = ST_FLASH;
                    frame_count_next = 8'(FLASH_FRAMES);
                end
            end
            ST_FLASH: begin
                if (click) begin
                    frame_count_next = 8'(FLASH_FRAMES);
                end else if (frame_count == 8'd0) begin
                    state_next = ST_IDLE;
                end else if (vsync_fall) begin
                    frame_count_next = frame_count - 8'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            frame_count  <= 8'd0;
            flash_active <= 1'b0;
            vsync_prev   <= 1'b1;
        end else begin
            state        <= state_next;
            frame_count  <= frame_count_next;
            flash_active <= (state_next == ST_FLASH);
            vsync_prev   <= vsync_in;
        end
    end

    logic [NUM_LAYERS-1:0] opaque;
    rgb444_t               sel_pixel;
    logic                  sel_is_flash_layer;
    rgb444_t               comp_pixel;

    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
`ifdef COLOR_KEY_TRANSPARENCY_EN
            opaque[i] = layer_valid[i] && (layer_pixel[12*i +: 12] != KEY_COLOR);
`else
            opaque[i] = layer_valid[i];
`endif
        end
    end

    // Walk from the lowest priority upward so the lowest-index opaque layer wins.
    always_comb begin
        sel_pixel          = BG_COLOR;
        sel_is_flash_layer = 1'b0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                sel_pixel          = layer_pixel[12*i +: 12];
                sel_is_flash_layer = (i == FLASH_LAYER);
            end
        end
        comp_pixel = sel_pixel;
        if ((state == ST_FLASH) && sel_is_flash_layer) begin
            comp_pixel = brighten(sel_pixel);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= 12'h000;
        end else begin
            hsync <= d_hsync;
            vsync <= d_vsync;
            rgb   <= d_video_on ? comp_pixel : 12'h000;
        end
    end

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed self-checking bench for pixel_compositor at default parameters.
// Key-colour expectations follow COLOR_KEY_TRANSPARENCY_EN when it is defined for the build.
module tb_pixel_compositor;

    logic        clk;
    logic        reset;
    logic        hsync_in;
    logic        vsync_in;
    logic        video_on_in;
    logic [47:0] layer_pixel;
    logic [3:0]  layer_valid;
    logic        click;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic        flash_active;

    int checks;
    int errors;

    pixel_compositor dut (
        .clk          (clk),
        .reset        (reset),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .video_on_in  (video_on_in),
        .layer_pixel  (layer_pixel),
        .layer_valid  (layer_valid),
        .click        (click),
        .hsync        (hsync),
        .vsync        (vsync),
        .rgb          (rgb),
        .flash_active (flash_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [11:0] l0, input logic [11:0] l1,
                                 input logic [11:0] l2, input logic [11:0] l3,
                                 input logic [3:0] valid, input logic von);
        layer_pixel = {l3, l2, l1, l0};
        layer_valid = valid;
        video_on_in = von;
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic checkOutput(input string tag, input logic [11:0] observed,
                               input logic [11:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic vsyncEdge();
        vsync_in = 1'b0;
        step();
        vsync_in = 1'b1;
        step();
    endtask

    int low_cnt;
    int first_low;

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        hsync_in    = 1'b1;
        vsync_in    = 1'b1;
        video_on_in = 1'b0;
        layer_pixel = '0;
        layer_valid = '0;
        click       = 1'b0;
        step();
        step();
        checkOutput("reset_rgb",   rgb, 12'h000);
        checkOutput("reset_hsync", {11'd0, hsync}, 12'd1);
        checkOutput("reset_vsync", {11'd0, vsync}, 12'd1);
        checkOutput("reset_flash", {11'd0, flash_active}, 12'd0);
        reset = 1'b0;
        step();

        // hsync pulse of 96 cycles must appear 2 cycles later with identical width
        low_cnt   = 0;
        first_low = -1;
        hsync_in  = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (k == 96) hsync_in = 1'b1;
            if (hsync == 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = k;
            end
        end
        checkOutput("hsync_first_low", 12'(first_low), 12'd2);
        checkOutput("hsync_low_count", 12'(low_cnt), 12'd96);

        // Priority selection
        applyStimulus(12'hABC, 12'h000, 12'h123, 12'h000, 4'b0101, 1'b1);
        checkOutput("prio_layer0", rgb, 12'hABC);
        applyStimulus(12'hABC, 12'h000, 12'h123, 12'h000, 4'b0100, 1'b1);
        checkOutput("prio_layer2", rgb, 12'h123);
        applyStimulus(12'hABC, 12'h000, 12'h123, 12'h000, 4'b0000, 1'b1);
        checkOutput("prio_bg", rgb, 12'h000);
        applyStimulus(12'h111, 12'h222, 12'h333, 12'h444, 4'b1010, 1'b1);
        checkOutput("prio_layer1", rgb, 12'h222);

        // Colour key
        applyStimulus(12'hF0F, 12'h456, 12'h000, 12'h000, 4'b0011, 1'b1);
`ifdef COLOR_KEY_TRANSPARENCY_EN
        checkOutput("key_transparent", rgb, 12'h456);
`else
        checkOutput("key_disabled", rgb, 12'hF0F);
`endif

        // Blanking
        applyStimulus(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 4'b1111, 1'b0);
        checkOutput("blank_rgb", rgb, 12'h000);

        // Flash: 8 frames, layer0 brightened
        applyStimulus(12'hC3E, 12'h000, 12'h000, 12'h000, 4'b0001, 1'b1);
        checkOutput("flash_pre_rgb", rgb, 12'hC3E);
        click = 1'b1;
        step();
        click = 1'b0;
        checkOutput("flash_start", {11'd0, flash_active}, 12'd1);
        step();
        checkOutput("flash_rgb", rgb, 12'hF7F);
        for (int e = 0; e < 7; e++) vsyncEdge();
        checkOutput("flash_after7", {11'd0, flash_active}, 12'd1);
        vsync_in = 1'b0;
        step();
        checkOutput("flash_edge8_cycle", {11'd0, flash_active}, 12'd1);
        vsync_in = 1'b1;
        step();
        checkOutput("flash_end", {11'd0, flash_active}, 12'd0);
        step();
        checkOutput("flash_end_rgb", rgb, 12'hC3E);

        // Click coincident with the 5th edge reloads the counter to 8
        click = 1'b1;
        step();
        click = 1'b0;
        for (int e = 0; e < 4; e++) vsyncEdge();
        vsync_in = 1'b0;
        click    = 1'b1;
        step();
        click    = 1'b0;
        vsync_in = 1'b1;
        step();
        for (int e = 0; e < 7; e++) vsyncEdge();
        checkOutput("reload_after7", {11'd0, flash_active}, 12'd1);
        vsync_in = 1'b0;
        step();
        checkOutput("reload_edge8_cycle", {11'd0, flash_active}, 12'd1);
        vsync_in = 1'b1;
        step();
        checkOutput("reload_end", {11'd0, flash_active}, 12'd0);

        // Reset mid-flash with a coincident click
        click = 1'b1;
        step();
        click = 1'b0;
        vsyncEdge();
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        step();
        step();
        checkOutput("pre_reset_flash", {11'd0, flash_active}, 12'd1);
        checkOutput("pre_reset_hsync", {11'd0, hsync}, 12'd0);
        reset = 1'b1;
        click = 1'b1;
        step();
        checkOutput("midreset_flash", {11'd0, flash_active}, 12'd0);
        checkOutput("midreset_rgb",   rgb, 12'h000);
        checkOutput("midreset_hsync", {11'd0, hsync}, 12'd1);
        checkOutput("midreset_vsync", {11'd0, vsync}, 12'd1);
        reset    = 1'b0;
        click    = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        step();
        checkOutput("post_reset_flash", {11'd0, flash_active}, 12'd0);
        step();
        step();
        checkOutput("post_reset_rgb", rgb, 12'hC3E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_compositor.md
PIXEL_COMPOSITOR -- requirements
Module: pixel_compositor

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, number of sprite layers; layer 0 has the highest priority.
REQ-002 SHALL have parameter ROM_LATENCY, default 1, read latency in cycles of each upstream image ROM.
REQ-003 SHALL have parameter BG_COLOR, default 12'h000, colour shown when no layer is opaque.
REQ-004 SHALL have parameter KEY_COLOR, default 12'hF0F, transparent colour key.
REQ-005 SHALL have parameter FLASH_LAYER, default 0, the layer brightened on a click.
REQ-006 SHALL have parameter FLASH_FRAMES, default 8, flash duration in frames, range 1..255.
REQ-007 SHALL have port clk, input, 1 bit, the single pixel clock.
REQ-008 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-009 SHALL have port hsync_in, input, 1 bit, active-low horizontal sync, aligned with the x/y sent to the ROMs.
REQ-010 SHALL have port vsync_in, input, 1 bit, active-low vertical sync, with the same alignment.
REQ-011 SHALL have port video_on_in, input, 1 bit, visible-area flag, with the same alignment.
REQ-012 SHALL have port layer_pixel, input, NUM_LAYERS*12 bits, 12-bit RGB444 per layer; layer i occupies bits [12i+11:12i].
REQ-013 SHALL have port layer_valid, input, NUM_LAYERS bits, per-layer in-bounds flag arriving with layer_pixel.
REQ-014 SHALL have port click, input, 1 bit, single-cycle click pulse.
REQ-015 SHALL have port hsync, output, 1 bit, delayed sync to the VGA pins.
REQ-016 SHALL have port vsync, output, 1 bit, delayed sync to the VGA pins.
REQ-017 SHALL have port rgb, output, 12 bits, composited pixel.
REQ-018 SHALL have port flash_active, output, 1 bit, high while a flash is running.

Function
REQ-019 SHALL delay hsync_in, vsync_in and video_on_in by ROM_LATENCY cycles in a shift register, so that they align with layer_pixel and layer_valid.
REQ-020 SHALL register all outputs, so that the total latency from sync input to hsync/vsync/rgb is ROM_LATENCY+1 cycles.
REQ-021 SHALL treat a layer as opaque when its valid bit is 1 and, when the key is enabled, its pixel is not KEY_COLOR.
REQ-022 SHALL output the lowest-index opaque layer; if no layer is opaque, SHALL output BG_COLOR.
REQ-023 SHALL output rgb = 12'h000 whenever the delayed video_on is 0, regardless of the layers.
REQ-024 SHALL implement a flash FSM with two states:
  - IDLE to FLASH on click, loading the frame counter with FLASH_FRAMES.
  - FLASH decrements the counter on each 1->0 transition of the undelayed vsync_in.
  - FLASH returns to IDLE in the cycle after the counter reaches 0.
REQ-025 SHALL reload the counter to FLASH_FRAMES on a click in FLASH; when click and a vsync edge coincide, the reload SHALL win.
REQ-026 SHALL drive flash_active = 1 exactly while the state is FLASH, as a registered output.
REQ-027 SHALL, in FLASH, add 4 to each nibble of the FLASH_LAYER pixel when that layer is selected, saturating each nibble at 4'hF with no carry between nibbles.

Reset
REQ-028 SHALL on reset set rgb=12'h000, hsync=1, vsync=1, flash_active=0, state=IDLE and counter=0.
REQ-029 SHALL on reset fill the delay lines with hsync=1, vsync=1, video_on=0.
REQ-030 SHALL abort an active flash immediately on reset mid-operation, and SHALL ignore a click coincident with reset.

Configuration
REQ-031 SHALL, with COLOR_KEY_TRANSPARENCY_EN defined, treat KEY_COLOR pixels as transparent per REQ-021.
REQ-032 SHALL, without COLOR_KEY_TRANSPARENCY_EN, treat every valid pixel as opaque, and KEY_COLOR SHALL be unused.

Structure
REQ-033 SHALL place in the shared package the RGB444 pixel typedef, the default BG_COLOR and KEY_COLOR constants, and the FSM state encoding.
REQ-034 SHALL implement the delay line as sub-module sync_delay (parameterised depth and width, synchronous reset value), instantiated once for {hsync, vsync, video_on}.

Verification
REQ-035 SHALL cover: hsync_in pulse 0 for 96 cycles with ROM_LATENCY=1 -> hsync low for 96 cycles starting exactly 2 cycles later.
REQ-036 SHALL cover: layer0 valid 12'hABC, layer2 valid 12'h123, video_on=1 -> rgb=12'hABC; with layer0 invalid -> 12'h123; all invalid -> 12'h000 (BG_COLOR).
REQ-037 SHALL cover: key enabled, layer0=12'hF0F valid, layer1=12'h456 valid -> rgb=12'h456; key disabled -> rgb=12'hF0F.
REQ-038 SHALL cover: click, then 8 vsync falling edges -> flash_active high until the cycle after the 8th edge; layer0 12'hC3E shown as 12'hF7F while flashing.
REQ-039 SHALL cover: click coincident with the 5th vsync edge -> counter=8, flash extended; reset asserted mid-flash -> flash_active=0, rgb=0, hsync=vsync=1 the next cycle.
REQ-040 SHALL cover: video_on_in=0 with all layers valid 12'hFFF -> rgb=12'h000.
